// File: rtl/fb_mcb_arbiter.sv
// fb_mcb_arbiter: shares the single DDR2 MCB command port between the HDMI
// capture writer and the frame reader, and rotates three frame banks so that
// capture never lands in the bank currently being read.
//
// Optional build macro: FB_ARB_STARVE_GUARD_EN
//   undefined : strict writer priority.
//   defined   : after RD_MAX_WAIT write grants issued while rd_req is pending,
//               the next arbitration goes to the reader.
//
// Command timing: one IDLE cycle (arbitration + latch), then CMD with
// cmd_en high until the MCB FIFO accepts it, so every command takes at
// least two cycles. Acks are combinational so the requester sees them in
// the same cycle the MCB accepts the command.
module fb_mcb_arbiter #(
    parameter int RD_MAX_WAIT = 8,
    parameter int DROP_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  calib_done,
    input  logic                  wr_req,
    input  logic [22:0]           wr_ofs,
    input  logic [5:0]            wr_bl,
    output logic                  wr_ack,
    input  logic                  rd_req,
    input  logic [22:0]           rd_ofs,
    input  logic [5:0]            rd_bl,
    output logic                  rd_ack,
    input  logic                  wr_frame_done,
    input  logic                  rd_frame_start,
    output logic [1:0]            wr_bank,
    output logic [1:0]            rd_bank,
    output logic                  rd_bank_valid,
    output logic [DROP_CNT_W-1:0] frames_dropped,
    output logic                  cmd_en,
    output logic [2:0]            cmd_instr,
    output logic [5:0]            cmd_bl,
    output logic [29:0]           cmd_byte_addr,
    input  logic                  cmd_full,
    output logic                  busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CMD  = 1'b1
    } state_t;

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

    // Lowest-index bank (0..2) that is neither of the two occupied banks.
    function automatic logic [1:0] pick_free_bank(input logic [1:0] bank_a,
                                                  input logic [1:0] bank_b);
        logic [1:0] free_bank;
        if ((bank_a != 2'd0) && (bank_b != 2'd0)) begin
            free_bank = 2'd0;
        end else if ((bank_a != 2'd1) && (bank_b != 2'd1)) begin
            free_bank = 2'd1;
        end else begin
            free_bank = 2'd2;
        end
        return free_bank;
    endfunction

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                  state_r, state_n;
    logic                    cmd_en_r, cmd_en_n;
    logic                    busy_r, busy_n;
    logic                    grant_rd_r, grant_rd_n;
    logic [2:0]              cmd_instr_r, cmd_instr_n;
    logic [5:0]              cmd_bl_r, cmd_bl_n;
    logic [29:0]             cmd_addr_r, cmd_addr_n;

    logic [1:0]              wr_bank_r, wr_bank_n;
    logic [1:0]              rd_bank_r, rd_bank_n;
    logic [1:0]              latest_r, latest_n;
    logic                    latest_valid_r, latest_valid_n;
    logic                    latest_read_r, latest_read_n;
    logic                    rd_bank_valid_r, rd_bank_valid_n;
    logic [DROP_CNT_W-1:0]   drop_cnt_r, drop_cnt_n;

    logic                    grant_fire_s;
    logic                    pick_rd_s;
    logic                    starve_hit_s;
    logic                    unused_ofs_bits_s;

    // Byte-lane bits of the offsets are forced to zero in the address.
    assign unused_ofs_bits_s = ^{wr_ofs[1:0], rd_ofs[1:0], 1'(RD_MAX_WAIT > 0)};

`ifdef FB_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(RD_MAX_WAIT + 1);
    logic [STARVE_W-1:0] starve_cnt_r;

    assign starve_hit_s = (starve_cnt_r == STARVE_W'(RD_MAX_WAIT));

    // Count write grants that bypassed a waiting reader; clear on read grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_fire_s && pick_rd_s) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else if (grant_fire_s && rd_req && !starve_hit_s) begin
            starve_cnt_r <= starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign starve_hit_s = 1'b0;
`endif

    // Arbitration and command sequencing: next state and next command fields.
    always_comb begin
        state_n      = state_r;
        cmd_en_n     = cmd_en_r;
        grant_rd_n   = grant_rd_r;
        cmd_instr_n  = cmd_instr_r;
        cmd_bl_n     = cmd_bl_r;
        cmd_addr_n   = cmd_addr_r;
        grant_fire_s = 1'b0;
        pick_rd_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (calib_done && (wr_req || rd_req)) begin
                    grant_fire_s = 1'b1;
                    pick_rd_s    = rd_req && (!wr_req || starve_hit_s);
                    state_n      = ST_CMD;
                    cmd_en_n     = 1'b1;
                    grant_rd_n   = pick_rd_s;
                    if (pick_rd_s) begin
                        cmd_instr_n = INSTR_RD;
                        cmd_bl_n    = rd_bl;
                        cmd_addr_n  = {5'b00000, rd_bank_r, rd_ofs[22:2], 2'b00};
                    end else begin
                        cmd_instr_n = INSTR_WR;
                        cmd_bl_n    = wr_bl;
                        cmd_addr_n  = {5'b00000, wr_bank_r, wr_ofs[22:2], 2'b00};
                    end
                end else begin
                    state_n  = ST_IDLE;
                    cmd_en_n = 1'b0;
                end
            end
            ST_CMD: begin
                if (!cmd_full) begin
                    state_n  = ST_IDLE;
                    cmd_en_n = 1'b0;
                end else begin
                    state_n  = ST_CMD;
                    cmd_en_n = 1'b1;
                end
            end
            default: begin
                state_n  = ST_IDLE;
                cmd_en_n = 1'b0;
            end
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    // Command FSM state and registered MCB command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cmd_en_r    <= 1'b0;
            busy_r      <= 1'b0;
            grant_rd_r  <= 1'b0;
            cmd_instr_r <= 3'b000;
            cmd_bl_r    <= 6'd0;
            cmd_addr_r  <= 30'd0;
        end else begin
            state_r     <= state_n;
            cmd_en_r    <= cmd_en_n;
            busy_r      <= busy_n;
            grant_rd_r  <= grant_rd_n;
            cmd_instr_r <= cmd_instr_n;
            cmd_bl_r    <= cmd_bl_n;
            cmd_addr_r  <= cmd_addr_n;
        end
    end

    // Bank rotation: frame completion is applied before reader frame start,
    // so a simultaneous start picks up the frame that just finished.
    always_comb begin
        wr_bank_n       = wr_bank_r;
        rd_bank_n       = rd_bank_r;
        latest_n        = latest_r;
        latest_valid_n  = latest_valid_r;
        latest_read_n   = latest_read_r;
        rd_bank_valid_n = rd_bank_valid_r;
        drop_cnt_n      = drop_cnt_r;
        if (wr_frame_done) begin
            if (latest_valid_r && !latest_read_r && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_n = drop_cnt_r + DROP_CNT_W'(1);
            end else begin
                drop_cnt_n = drop_cnt_r;
            end
            latest_n       = wr_bank_r;
            latest_valid_n = 1'b1;
            latest_read_n  = 1'b0;
        end else begin
            latest_n = latest_r;
        end
        if (rd_frame_start && latest_valid_n) begin
            rd_bank_n       = latest_n;
            latest_read_n   = 1'b1;
            rd_bank_valid_n = 1'b1;
        end else begin
            rd_bank_n = rd_bank_r;
        end
        if (wr_frame_done) begin
            wr_bank_n = pick_free_bank(latest_n, rd_bank_n);
        end else begin
            wr_bank_n = wr_bank_r;
        end
    end

    // Bank bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_r       <= 2'd0;
            rd_bank_r       <= 2'd2;
            latest_r        <= 2'd1;
            latest_valid_r  <= 1'b0;
            latest_read_r   <= 1'b0;
            rd_bank_valid_r <= 1'b0;
            drop_cnt_r      <= {DROP_CNT_W{1'b0}};
        end else begin
            wr_bank_r       <= wr_bank_n;
            rd_bank_r       <= rd_bank_n;
            latest_r        <= latest_n;
            latest_valid_r  <= latest_valid_n;
            latest_read_r   <= latest_read_n;
            rd_bank_valid_r <= rd_bank_valid_n;
            drop_cnt_r      <= drop_cnt_n;
        end
    end

    assign cmd_en         = cmd_en_r;
    assign cmd_instr      = cmd_instr_r;
    assign cmd_bl         = cmd_bl_r;
    assign cmd_byte_addr  = cmd_addr_r;
    assign busy           = busy_r;
    assign wr_ack         = cmd_en_r && !cmd_full && !grant_rd_r;
    assign rd_ack         = cmd_en_r && !cmd_full && grant_rd_r;
    assign wr_bank        = wr_bank_r;
    assign rd_bank        = rd_bank_r;
    assign rd_bank_valid  = rd_bank_valid_r;
    assign frames_dropped = drop_cnt_r;

endmodule

// File: tb/tb_fb_mcb_arbiter.sv
// Self-checking bench for fb_mcb_arbiter: directed sequences, a frame-pulse
// vector table, and a randomized run against a transaction-level model.
module tb_fb_mcb_arbiter;

    localparam int RD_MAX_WAIT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        calib_done, wr_req, rd_req, wr_ack, rd_ack;
    logic [22:0] wr_ofs, rd_ofs;
    logic [5:0]  wr_bl, rd_bl, cmd_bl;
    logic        wr_frame_done, rd_frame_start, rd_bank_valid;
    logic [1:0]  wr_bank, rd_bank;
    logic [15:0] frames_dropped;
    logic        cmd_en, cmd_full, busy;
    logic [2:0]  cmd_instr;
    logic [29:0] cmd_byte_addr;

    int n_vec = 0;
    int n_err = 0;

    fb_mcb_arbiter #(.RD_MAX_WAIT(RD_MAX_WAIT), .DROP_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .calib_done(calib_done),
        .wr_req(wr_req), .wr_ofs(wr_ofs), .wr_bl(wr_bl), .wr_ack(wr_ack),
        .rd_req(rd_req), .rd_ofs(rd_ofs), .rd_bl(rd_bl), .rd_ack(rd_ack),
        .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
        .wr_bank(wr_bank), .rd_bank(rd_bank), .rd_bank_valid(rd_bank_valid),
        .frames_dropped(frames_dropped), .cmd_en(cmd_en), .cmd_instr(cmd_instr),
        .cmd_bl(cmd_bl), .cmd_byte_addr(cmd_byte_addr), .cmd_full(cmd_full),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_en"}, 64'(cmd_en), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_wr_ack"}, 64'(wr_ack), 64'd0);
        check({tag, "_instr_bl_addr"}, 64'({cmd_instr, cmd_bl, cmd_byte_addr}), 64'd0);
        check({tag, "_wr_bank"}, 64'(wr_bank), 64'd0);
        check({tag, "_rd_bank"}, 64'(rd_bank), 64'd2);
        check({tag, "_rd_bank_valid"}, 64'(rd_bank_valid), 64'd0);
        check({tag, "_frames_dropped"}, 64'(frames_dropped), 64'd0);
    endtask

    function automatic logic [29:0] mk_addr(input logic [1:0] bank, input logic [22:0] ofs);
        return {5'b00000, bank, ofs[22:2], 2'b00};
    endfunction

    // ---------------- frame-pulse vector table ----------------
    typedef struct {
        logic        wd;
        logic        rs;
        logic [1:0]  wr;
        logic [1:0]  rd;
        logic        rbv;
        logic [15:0] drop;
    } fvec_t;
    fvec_t tbl [9];

    // ---------------- reference model state ----------------
    logic [1:0]  m_wr, m_rd, m_latest;
    logic        m_lv, m_lr, m_rbv;
    int          m_drop;
    logic        m_act, m_is_rd;
    logic [2:0]  m_instr;
    logic [5:0]  m_bl;
    logic [29:0] m_addr;
    int          m_starve;

    task automatic model_reset();
        m_wr = 2'd0; m_rd = 2'd2; m_latest = 2'd1;
        m_lv = 1'b0; m_lr = 1'b0; m_rbv = 1'b0; m_drop = 0;
        m_act = 1'b0; m_is_rd = 1'b0; m_instr = 3'd0; m_bl = 6'd0; m_addr = 30'd0;
        m_starve = 0;
    endtask

    // One clock of the specification's rules, using the inputs as they were at the edge.
    task automatic model_step();
        logic take_rd;
        if (m_act) begin
            if (!cmd_full) m_act = 1'b0;
        end else if (calib_done && (wr_req || rd_req)) begin
            take_rd = rd_req && !wr_req;
`ifdef FB_ARB_STARVE_GUARD_EN
            if (rd_req && m_starve == RD_MAX_WAIT) take_rd = 1'b1;
            if (take_rd) m_starve = 0;
            else if (rd_req && m_starve < RD_MAX_WAIT) m_starve++;
`endif
            m_act   = 1'b1;
            m_is_rd = take_rd;
            m_instr = take_rd ? 3'b001 : 3'b000;
            m_bl    = take_rd ? rd_bl : wr_bl;
            m_addr  = take_rd ? mk_addr(m_rd, rd_ofs) : mk_addr(m_wr, wr_ofs);
        end
        if (wr_frame_done) begin
            if (m_lv && !m_lr && m_drop < 65535) m_drop++;
            m_latest = m_wr; m_lv = 1'b1; m_lr = 1'b0;
        end
        if (rd_frame_start && m_lv) begin
            m_rd = m_latest; m_lr = 1'b1; m_rbv = 1'b1;
        end
        if (wr_frame_done) begin
            for (int b = 2; b >= 0; b--) begin
                if (2'(b) != m_latest && 2'(b) != m_rd) m_wr = 2'(b);
            end
        end
    endtask

    initial begin
        logic [22:0] ofs_v;
        int          wr_cnt, rd_cnt, wr_before_rd;
        logic        exp_wa, exp_ra, last_wa, last_ra;
        logic [63:0] act_t, exp_t;

        tbl[0] = '{1'b1, 1'b0, 2'd1, 2'd2, 1'b0, 16'd0};
        tbl[1] = '{1'b0, 1'b1, 2'd1, 2'd0, 1'b1, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 2'd2, 2'd0, 1'b1, 16'd0};
        tbl[3] = '{1'b1, 1'b0, 2'd1, 2'd0, 1'b1, 16'd1};
        tbl[4] = '{1'b1, 1'b1, 2'd0, 2'd1, 1'b1, 16'd2};
        tbl[5] = '{1'b0, 1'b1, 2'd0, 2'd1, 1'b1, 16'd2};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 16'd2};
        tbl[7] = '{1'b1, 1'b0, 2'd2, 2'd1, 1'b1, 16'd2};
        tbl[8] = '{1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 16'd3};

        rst = 1'b1; calib_done = 1'b0; cmd_full = 1'b0;
        wr_req = 1'b0; wr_ofs = 23'd0; wr_bl = 6'd0;
        rd_req = 1'b0; rd_ofs = 23'd0; rd_bl = 6'd0;
        wr_frame_done = 1'b0; rd_frame_start = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1 rst = 1'b0;

        // ---- no grants before calibration ----
        wr_req = 1'b1; wr_ofs = 23'h5A5A5F; wr_bl = 6'd15;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("no_cmd_before_calib", 64'(cmd_en), 64'd0);
        end
        @(posedge clk); #1 calib_done = 1'b1;
        @(posedge clk); @(negedge clk);
        ofs_v = wr_ofs;
        check("calib_cmd_en", 64'(cmd_en), 64'd1);
        check("calib_instr", 64'(cmd_instr), 64'd0);
        check("calib_bl", 64'(cmd_bl), 64'd15);
        check("calib_addr", 64'(cmd_byte_addr), 64'(mk_addr(2'd0, ofs_v)));
        check("calib_acks", 64'({wr_ack, rd_ack}), 64'b10);
        @(posedge clk); #1 wr_req = 1'b0;
        @(negedge clk);
        check("after_ack_idle", 64'({cmd_en, busy}), 64'd0);

        // ---- cmd_full back-pressure ----
        @(posedge clk); #1 cmd_full = 1'b1; wr_req = 1'b1; wr_ofs = 23'h000123; wr_bl = 6'd3;
        @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("full_hold_en", 64'({cmd_en, busy, wr_ack}), 64'b110);
            check("full_hold_addr", 64'(cmd_byte_addr), 64'(mk_addr(2'd0, 23'h000123)));
        end
        @(posedge clk); #1 cmd_full = 1'b0;
        @(negedge clk);
        check("full_release_ack", 64'({cmd_en, wr_ack}), 64'b11);
        @(posedge clk); #1 wr_ofs = 23'h3FFFFF; wr_bl = 6'd63;
        @(negedge clk);
        check("gap_after_ack", 64'(cmd_en), 64'd0);
        @(negedge clk);
        check("next_cmd_en", 64'(cmd_en), 64'd1);
        check("next_cmd_addr", 64'({cmd_bl, cmd_byte_addr}), 64'({6'd63, mk_addr(2'd0, 23'h3FFFFF)}));
        @(posedge clk); #1 wr_req = 1'b0;

        // ---- both requesters held ----
        @(posedge clk); #1 wr_req = 1'b1; rd_req = 1'b1; rd_ofs = 23'h000444; rd_bl = 6'd7;
        wr_cnt = 0; rd_cnt = 0; wr_before_rd = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rd_ack && wr_before_rd < 0) wr_before_rd = wr_cnt;
            if (wr_ack) wr_cnt++;
            if (rd_ack) rd_cnt++;
        end
        @(posedge clk); #1 wr_req = 1'b0; rd_req = 1'b0;
`ifdef FB_ARB_STARVE_GUARD_EN
        check("starve_wr_before_rd", 64'(wr_before_rd), 64'(RD_MAX_WAIT));
        check("starve_rd_grants", 64'(rd_cnt), 64'd2);
        check("starve_wr_grants", 64'(wr_cnt), 64'd18);
`else
        check("prio_rd_grants", 64'(rd_cnt), 64'd0);
        check("prio_wr_grants", 64'(wr_cnt), 64'd20);
`endif

        // ---- reset while in CMD ----
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 wr_frame_done = 1'b1;
        end
        wr_req = 1'b1; cmd_full = 1'b1;
        @(posedge clk); #1 wr_frame_done = 1'b0;
        @(posedge clk); @(negedge clk);
        check("pre_rst_state", 64'({cmd_en, wr_bank, frames_dropped}), 64'({1'b1, 2'd1, 16'd2}));
        #2 rst = 1'b1;
        #1 check_reset_state("midrst");
        wr_req = 1'b0; cmd_full = 1'b0;
        @(posedge clk); #1 rst = 1'b0;

        // ---- frame-pulse table ----
        for (int i = 0; i < 9; i++) begin
            wr_frame_done = tbl[i].wd; rd_frame_start = tbl[i].rs;
            @(posedge clk); #1 wr_frame_done = 1'b0; rd_frame_start = 1'b0;
            @(negedge clk);
            check($sformatf("frame_vec%0d", i),
                  64'({wr_bank, rd_bank, rd_bank_valid, frames_dropped}),
                  64'({tbl[i].wr, tbl[i].rd, tbl[i].rbv, tbl[i].drop}));
        end

        // ---- randomized run against the model ----
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        last_wa = 1'b0; last_ra = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            exp_wa = m_act && !cmd_full && !m_is_rd;
            exp_ra = m_act && !cmd_full && m_is_rd;
            act_t = {cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_ack, rd_ack, busy,
                     wr_bank, rd_bank, rd_bank_valid, frames_dropped};
            exp_t = {m_act, m_instr, m_bl, m_addr, exp_wa, exp_ra, m_act,
                     m_wr, m_rd, m_rbv, 16'(m_drop)};
            check($sformatf("rand_cycle%0d", i), act_t, exp_t);
            last_wa = exp_wa; last_ra = exp_ra;
            @(posedge clk);
            model_step();
            #1;
            if (!wr_req || last_wa) begin
                wr_req = ($urandom_range(0, 99) < 60);
                wr_ofs = 23'($urandom); wr_bl = 6'($urandom);
            end
            if (!rd_req || last_ra) begin
                rd_req = ($urandom_range(0, 99) < 50);
                rd_ofs = 23'($urandom); rd_bl = 6'($urandom);
            end
            cmd_full       = ($urandom_range(0, 99) < 30);
            calib_done     = ($urandom_range(0, 99) != 0);
            wr_frame_done  = ($urandom_range(0, 99) < 8);
            rd_frame_start = ($urandom_range(0, 99) < 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_mcb_arbiter.md
Name: fb_mcb_arbiter

Overview:
- Shares the single DDR2 MCB command port between the HDMI capture writer and the frame reader that feeds the encoder/USB path.
- Manages triple-buffered frame banks so capture never overwrites the frame being read.
- Sits between the capture/read engines and the MCB user command interface; gates all traffic until memory calibration completes.

Parameters:
- RD_MAX_WAIT, 8, consecutive write grants tolerated while rd_req is pending (used only with the optional feature).
- DROP_CNT_W, 16, width of the dropped-frame counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- calib_done  in  1  MCB calibration complete; no grants while low.
- wr_req  in  1  capture command request.
- wr_ofs  in  23  capture byte offset within the bank; bits [1:0] are ignored and forced 0.
- wr_bl  in  6  capture burst length minus 1.
- wr_ack  out  1  capture command accepted (1-cycle pulse).
- rd_req, rd_ofs, rd_bl, rd_ack: same widths and meaning for the reader.
- wr_frame_done  in  1  pulse: capture finished the current bank.
- rd_frame_start  in  1  pulse: reader begins a new frame.
- wr_bank  out  2  bank being captured.
- rd_bank  out  2  bank being read.
- rd_bank_valid  out  1  rd_bank holds a completed frame.
- frames_dropped  out  DROP_CNT_W  completed frames overwritten before being read; saturates.
- cmd_en  out  1  MCB command strobe.
- cmd_instr  out  3  000 = write, 001 = read.
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  30  {5'b0, bank[1:0], ofs[22:2], 2'b00}.
- cmd_full  in  1  MCB command FIFO full.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset values: cmd_en=0, cmd_instr=0, cmd_bl=0, cmd_byte_addr=0, wr_ack=0, rd_ack=0, busy=0, wr_bank=0, rd_bank=2, latest=1, latest_valid=0, latest_read=0, rd_bank_valid=0, frames_dropped=0, starvation counter=0.
- Assertion of rst mid-operation forces all of the above immediately, including dropping cmd_en. A request in flight is lost; requesters must re-request.
- Requester handshake: req is held high with stable ofs/bl until its ack. The ack is combinational: cmd_en & !cmd_full & (grant is that requester). The requester may drop req or present a new request on the following edge.
- FSM IDLE: if calib_done and any req, choose a grant, latch instr/bl/addr using the bank value current in this cycle, and go to CMD. Otherwise stay in IDLE.
- FSM CMD: cmd_en=1, outputs stable. When !cmd_full, the ack pulses and the FSM returns to IDLE at the next edge. While cmd_full, hold in CMD indefinitely.
- Minimum of 2 cycles per command; there is no back-to-back issue.
- Priority: the writer wins when both requests are present (capture is real-time).
- Bank sampling: bank is sampled at grant. A frame-pulse arriving while in CMD does not alter the address already latched.
- wr_frame_done handling, in this order:
  - If latest_valid & !latest_read, frames_dropped increments (saturating).
  - latest <= wr_bank; latest_valid <= 1; latest_read <= 0.
  - wr_bank <= lowest-index bank that is not the new latest and not the new rd_bank.
- rd_frame_start handling:
  - If latest_valid: rd_bank <= latest; latest_read <= 1; rd_bank_valid <= 1.
  - Otherwise no change.
- Both pulses in the same cycle: wr_frame_done is applied first, so the reader takes the just-completed bank. wr_bank is then computed against the updated rd_bank.
- The invariant wr_bank != rd_bank holds at all times after reset.

Optional Feature:
- Macro: FB_ARB_STARVE_GUARD_EN.
- Defined:
  - A counter increments on each write grant issued while rd_req is high.
  - When the counter equals RD_MAX_WAIT, the next arbitration grants the reader even if wr_req is high.
  - The counter clears on any read grant.
- Undefined: strict writer priority; no counter logic is present.

Test Plan:
- Reset release with calib_done=0 and wr_req=1 held for 20 cycles -> cmd_en stays 0. Raise calib_done -> cmd_en the next cycle with cmd_instr=000 and cmd_byte_addr = {5'b0, 2'd0, ofs[22:2], 2'b00}.
- wr_req and rd_req both held, cmd_full=0 -> writer granted every command and rd_ack never fires. With FB_ARB_STARVE_GUARD_EN -> read grant after exactly 8 write grants.
- Hold cmd_full=1 for 5 cycles during CMD -> cmd_en and the address remain stable for 5 cycles. Ack fires on the cycle cmd_full drops; next cmd_en no earlier than 2 cycles later.
- Frame pulses from reset:
  - wr_frame_done -> latest=0, wr_bank=1.
  - rd_frame_start -> rd_bank=0, rd_bank_valid=1.
  - wr_frame_done twice with no read -> frames_dropped=1, wr_bank never equals rd_bank.
- wr_frame_done and rd_frame_start in the same cycle, with wr_bank=1, rd_bank=0, latest=2 -> rd_bank=1, latest=1, wr_bank=0.
- Assert rst while in CMD -> cmd_en=0 in the same cycle; all banks and counters return to reset values.
